idma_axil_read_mo: RTL and testbench

- AXI-Lite read task of the iDMA transport layer with up to NumOutstanding reads in flight.
- Decouples read meta requests (AR) from read datapath requests (r_dp). Each r_dp descriptor (offset/tailer/shift) is queued in a FIFO and paired in order with returning R beats.
- Realigns strobes into the shared byte-lane buffer.
- Registers the r_dp response and optionally drops error beats.

---
 rtl/idma_axil_pkg.sv | 25 ++
 rtl/fifo_v3.sv | 81 ++++++++
 rtl/idma_axil_read_mo.sv | 153 +++++++++++++++
 tb/tb_idma_axil_read_mo.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_axil_pkg.sv
// Shared AXI-Lite iDMA types: response encodings and the read datapath descriptor.
package idma_axil_pkg;

  // Descriptor fields are sized for the widest supported bus (2048 bits);
  // narrower instances zero-extend into them.
  localparam int unsigned MaxOffW = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef struct packed {
    logic [MaxOffW-1:0] offset;
    logic [MaxOffW-1:0] tailer;
    logic [MaxOffW-1:0] shift;
  } r_desc_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != 2'(RESP_OKAY);
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// In-order FIFO with optional fall-through; synchronous active-high reset.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  is_empty, is_full, store, do_pop;

  function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] ptr);
    return (ptr == AddrW'(DEPTH - 1)) ? '0 : ptr + AddrW'(1);
  endfunction

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CntW'(DEPTH));
  // A fall-through push into an empty FIFO that is popped at once is never stored.
  assign store    = push_i & (~is_full | pop_i) & ~(FALL_THROUGH & is_empty & pop_i);
  assign do_pop   = pop_i & ~is_empty;

  assign full_o  = is_full;
  assign empty_o = is_empty & ~(FALL_THROUGH & push_i);
  assign data_o  = (FALL_THROUGH && is_empty) ? data_i : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (store) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (store && !do_pop) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (!store && do_pop) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/idma_axil_read_mo.sv
// AXI-Lite read task with multiple outstanding ARs; pairs queued r_dp descriptors
// in order with returning R beats and pushes realigned lanes into the byte buffer.
module idma_axil_read_mo
  import idma_axil_pkg::*;
#(
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned NumOutstanding = 4,
  parameter bit          DropOnError    = 1'b1,
  parameter int unsigned StrbWidth      = DataWidth / 8,
  parameter int unsigned OffW           = $clog2(StrbWidth)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [OffW-1:0]                       r_dp_offset_i,
  input  logic [OffW-1:0]                       r_dp_tailer_i,
  input  logic [OffW-1:0]                       r_dp_shift_i,
  input  logic                                  r_dp_valid_i,
  output logic                                  r_dp_ready_o,
  output logic [1:0]                            r_dp_resp_o,
  output logic                                  r_dp_first_o,
  output logic                                  r_dp_last_o,
  output logic                                  r_dp_valid_o,
  input  logic                                  r_dp_ready_i,
  input  logic [AddrWidth-1:0]                  ar_addr_i,
  input  logic [2:0]                            ar_prot_i,
  input  logic                                  ar_valid_i,
  output logic                                  ar_ready_o,
  output logic [AddrWidth-1:0]                  m_ar_addr_o,
  output logic [2:0]                            m_ar_prot_o,
  output logic                                  m_ar_valid_o,
  input  logic                                  m_ar_ready_i,
  input  logic [DataWidth-1:0]                  m_r_data_i,
  input  logic [1:0]                            m_r_resp_i,
  input  logic                                  m_r_valid_i,
  output logic                                  m_r_ready_o,
  output logic [DataWidth-1:0]                  buffer_in_o,
  output logic [StrbWidth-1:0]                  buffer_in_valid_o,
  input  logic [StrbWidth-1:0]                  buffer_in_ready_i,
  output logic                                  busy_o,
  output logic [$clog2(NumOutstanding+1)-1:0]   outstanding_o
);

  localparam int unsigned CntW = $clog2(NumOutstanding + 1);

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [1:0]             resp_q, resp_d;

  r_desc_t                desc_in, desc_head;
  logic                   fifo_full, fifo_empty, fifo_push;
  logic                   slot_avail, ar_hs, r_hs, drop_beat;
  logic                   in_ready, slot_free;
  logic [StrbWidth-1:0]   lo_mask, hi_mask, am, mask_in;
  logic [2*StrbWidth-1:0] rot;

  // AR pass-through, throttled by the registered in-flight count.
  assign slot_avail   = (cnt_q < CntW'(NumOutstanding));
  assign m_ar_valid_o = ar_valid_i & slot_avail;
  assign ar_ready_o   = m_ar_ready_i & slot_avail;
  assign m_ar_addr_o  = ar_addr_i;
  assign m_ar_prot_o  = ar_prot_i;
  assign ar_hs        = ar_valid_i & ar_ready_o;

  always_comb begin
    desc_in        = '0;
    desc_in.offset = MaxOffW'(r_dp_offset_i);
    desc_in.tailer = MaxOffW'(r_dp_tailer_i);
    desc_in.shift  = MaxOffW'(r_dp_shift_i);
  end

  assign r_dp_ready_o = ~fifo_full;
  assign fifo_push    = r_dp_valid_i & r_dp_ready_o;

  fifo_v3 #(
    .FALL_THROUGH ( 1'b0             ),
    .DATA_WIDTH   ( $bits(r_desc_t)  ),
    .DEPTH        ( NumOutstanding   )
  ) i_desc_fifo (
    .clk_i   ( clk_i      ),
    .rst_i   ( rst_i      ),
    .flush_i ( 1'b0       ),
    .full_o  ( fifo_full  ),
    .empty_o ( fifo_empty ),
    .data_i  ( desc_in    ),
    .push_i  ( fifo_push  ),
    .data_o  ( desc_head  ),
    .pop_i   ( r_hs       )
  );

  // Lane mask of the head descriptor, rotated right by shift into buffer lanes.
  always_comb begin
    lo_mask = {StrbWidth{1'b1}} << desc_head.offset;
    hi_mask = {StrbWidth{1'b1}};
    if (desc_head.tailer != '0) begin
      hi_mask = {StrbWidth{1'b1}} >> (StrbWidth - 32'(desc_head.tailer));
    end
    am      = lo_mask & hi_mask;
    rot     = {am, am} >> desc_head.shift;
    mask_in = rot[StrbWidth-1:0];
  end

  assign in_ready    = &(buffer_in_ready_i | ~mask_in);
  assign slot_free   = ~resp_valid_q | r_dp_ready_i;
  assign m_r_ready_o = ~fifo_empty & in_ready & slot_free;
  assign r_hs        = m_r_valid_i & m_r_ready_o;
  assign drop_beat   = DropOnError & resp_is_err(m_r_resp_i);

  assign buffer_in_o       = m_r_data_i;
  assign buffer_in_valid_o = (r_hs && !drop_beat) ? mask_in : '0;

  always_comb begin
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    case ({ar_hs, r_hs})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A reload wins over a drain so back-to-back beats keep the slot full.
    if (r_hs) begin
      resp_valid_d = 1'b1;
      resp_d       = m_r_resp_i;
    end else if (r_dp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign r_dp_valid_o  = resp_valid_q;
  assign r_dp_resp_o   = resp_q;
  assign r_dp_first_o  = 1'b1;
  assign r_dp_last_o   = 1'b1;
  assign busy_o        = (cnt_q != '0) | ~fifo_empty | resp_valid_q;
  assign outstanding_o = cnt_q;

  r_beat_without_desc_a : assert property (
    @(posedge clk_i) disable iff (rst_i) !(m_r_valid_i && fifo_empty)
  );

endmodule

// File: tb/tb_idma_axil_read_mo.sv
// Scoreboard bench for idma_axil_read_mo: directed scenarios plus randomized bursts,
// with a second instance (DropOnError=0) run in lockstep on the same stimulus.
module tb_idma_axil_read_mo;

  localparam int unsigned NO = 4;

  typedef struct {
    int off;
    int tail;
    int sh;
  } tdesc_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [2:0]  r_dp_offset_i, r_dp_tailer_i, r_dp_shift_i;
  logic        r_dp_valid_i, r_dp_ready_i;
  logic [31:0] ar_addr_i;
  logic [2:0]  ar_prot_i;
  logic        ar_valid_i, m_ar_ready_i;
  logic [63:0] m_r_data_i;
  logic [1:0]  m_r_resp_i;
  logic        m_r_valid_i;
  logic [7:0]  buffer_in_ready_i;

  logic        r_dp_ready_o, r_dp_first_o, r_dp_last_o, r_dp_valid_o;
  logic [1:0]  r_dp_resp_o;
  logic        ar_ready_o, m_ar_valid_o, m_r_ready_o, busy_o;
  logic [31:0] m_ar_addr_o;
  logic [2:0]  m_ar_prot_o, outstanding_o;
  logic [63:0] buffer_in_o;
  logic [7:0]  buffer_in_valid_o;

  logic        nd_r_dp_ready_o, nd_r_dp_first_o, nd_r_dp_last_o, nd_r_dp_valid_o;
  logic [1:0]  nd_r_dp_resp_o;
  logic        nd_ar_ready_o, nd_m_ar_valid_o, nd_m_r_ready_o, nd_busy_o;
  logic [31:0] nd_m_ar_addr_o;
  logic [2:0]  nd_m_ar_prot_o, nd_outstanding_o;
  logic [63:0] nd_buffer_in_o;
  logic [7:0]  nd_buffer_in_valid_o;

  int total = 0;
  int bad   = 0;
  logic rnd_en = 1'b0;

  always #5 clk = ~clk;

  idma_axil_read_mo #(.DataWidth(64), .AddrWidth(32), .NumOutstanding(NO), .DropOnError(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .r_dp_offset_i(r_dp_offset_i), .r_dp_tailer_i(r_dp_tailer_i), .r_dp_shift_i(r_dp_shift_i),
    .r_dp_valid_i(r_dp_valid_i), .r_dp_ready_o(r_dp_ready_o), .r_dp_resp_o(r_dp_resp_o),
    .r_dp_first_o(r_dp_first_o), .r_dp_last_o(r_dp_last_o),
    .r_dp_valid_o(r_dp_valid_o), .r_dp_ready_i(r_dp_ready_i),
    .ar_addr_i(ar_addr_i), .ar_prot_i(ar_prot_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .m_ar_addr_o(m_ar_addr_o), .m_ar_prot_o(m_ar_prot_o), .m_ar_valid_o(m_ar_valid_o),
    .m_ar_ready_i(m_ar_ready_i),
    .m_r_data_i(m_r_data_i), .m_r_resp_i(m_r_resp_i), .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o),
    .buffer_in_o(buffer_in_o), .buffer_in_valid_o(buffer_in_valid_o), .buffer_in_ready_i(buffer_in_ready_i),
    .busy_o(busy_o), .outstanding_o(outstanding_o)
  );

  idma_axil_read_mo #(.DataWidth(64), .AddrWidth(32), .NumOutstanding(NO), .DropOnError(1'b0)) dut_nd (
    .clk_i(clk), .rst_i(rst_i),
    .r_dp_offset_i(r_dp_offset_i), .r_dp_tailer_i(r_dp_tailer_i), .r_dp_shift_i(r_dp_shift_i),
    .r_dp_valid_i(r_dp_valid_i), .r_dp_ready_o(nd_r_dp_ready_o), .r_dp_resp_o(nd_r_dp_resp_o),
    .r_dp_first_o(nd_r_dp_first_o), .r_dp_last_o(nd_r_dp_last_o),
    .r_dp_valid_o(nd_r_dp_valid_o), .r_dp_ready_i(r_dp_ready_i),
    .ar_addr_i(ar_addr_i), .ar_prot_i(ar_prot_i), .ar_valid_i(ar_valid_i), .ar_ready_o(nd_ar_ready_o),
    .m_ar_addr_o(nd_m_ar_addr_o), .m_ar_prot_o(nd_m_ar_prot_o), .m_ar_valid_o(nd_m_ar_valid_o),
    .m_ar_ready_i(m_ar_ready_i),
    .m_r_data_i(m_r_data_i), .m_r_resp_i(m_r_resp_i), .m_r_valid_i(m_r_valid_i), .m_r_ready_o(nd_m_r_ready_o),
    .buffer_in_o(nd_buffer_in_o), .buffer_in_valid_o(nd_buffer_in_valid_o),
    .buffer_in_ready_i(buffer_in_ready_i),
    .busy_o(nd_busy_o), .outstanding_o(nd_outstanding_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: handshake timeout @%0t", nm, $time);
  endtask

  // Lane j of the buffer receives source lane (j+shift) mod 8 when that lane lies in [off, tail).
  function automatic logic [7:0] model_mask(input tdesc_t d);
    logic [7:0] m;
    int lane;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      lane = (j + d.sh) % 8;
      m[j] = (lane >= d.off) && ((d.tail == 0) || (lane < d.tail));
    end
    return m;
  endfunction

  // Scoreboard / reference model, sampled on the falling edge.
  tdesc_t     descq[$];
  int         mcnt   = 0;
  logic       mvalid = 1'b0;
  logic [1:0] mresp  = 2'b00;

  initial begin : monitor
    tdesc_t     d, hd;
    logic [7:0] hm;
    logic       e_rready, e_arready, e_dready, e_busy, ar_hs, r_hs;
    logic [12:0] e_ctl;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        descq.delete();
        mcnt   = 0;
        mvalid = 1'b0;
        mresp  = 2'b00;
      end else begin
        hm = '0;
        if (descq.size() != 0) begin
          hd = descq[0];
          hm = model_mask(hd);
        end
        e_dready  = (descq.size() < NO);
        e_arready = m_ar_ready_i && (mcnt < NO);
        e_rready  = (descq.size() != 0) && ((buffer_in_ready_i | ~hm) == 8'hFF) && (!mvalid || r_dp_ready_i);
        e_busy    = (mcnt != 0) || (descq.size() != 0) || mvalid;
        e_ctl = {e_dready, (mvalid ? mresp : 2'b00), mvalid, e_arready, ar_valid_i && (mcnt < NO),
                 e_rready, e_busy, 3'(mcnt), 1'b1, 1'b1};
        chk("ctl", {r_dp_ready_o, (r_dp_valid_o ? r_dp_resp_o : 2'b00), r_dp_valid_o, ar_ready_o,
                    m_ar_valid_o, m_r_ready_o, busy_o, outstanding_o, r_dp_first_o, r_dp_last_o}, 64'(e_ctl));
        chk("nd_ctl", {nd_r_dp_ready_o, (nd_r_dp_valid_o ? nd_r_dp_resp_o : 2'b00), nd_r_dp_valid_o,
                       nd_ar_ready_o, nd_m_ar_valid_o, nd_m_r_ready_o, nd_busy_o, nd_outstanding_o,
                       nd_r_dp_first_o, nd_r_dp_last_o}, 64'(e_ctl));
        ar_hs = ar_valid_i && e_arready;
        r_hs  = m_r_valid_i && e_rready;
        if (ar_hs) begin
          chk("ar_pass", {m_ar_addr_o, m_ar_prot_o}, {ar_addr_i, ar_prot_i});
          chk("nd_ar_pass", {nd_m_ar_addr_o, nd_m_ar_prot_o}, {ar_addr_i, ar_prot_i});
        end
        if (r_hs) begin
          d = descq.pop_front();
          chk("buf_valid", buffer_in_valid_o, (m_r_resp_i != 2'b00) ? 8'h00 : model_mask(d));
          chk("nd_buf_valid", nd_buffer_in_valid_o, model_mask(d));
          chk("buf_data", buffer_in_o, m_r_data_i);
          chk("nd_buf_data", nd_buffer_in_o, m_r_data_i);
          mvalid = 1'b1;
          mresp  = m_r_resp_i;
        end else begin
          chk("buf_idle", {buffer_in_valid_o, nd_buffer_in_valid_o}, 64'h0);
          if (r_dp_ready_i) mvalid = 1'b0;
        end
        if (r_dp_valid_i && e_dready) begin
          d.off  = int'(r_dp_offset_i);
          d.tail = int'(r_dp_tailer_i);
          d.sh   = int'(r_dp_shift_i);
          descq.push_back(d);
        end
        mcnt = mcnt + (ar_hs ? 1 : 0) - (r_hs ? 1 : 0);
      end
    end
  end

  // Random consumer/buffer backpressure while enabled.
  initial begin : backpressure
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) begin
        r_dp_ready_i      = ($urandom_range(0, 3) != 0);
        buffer_in_ready_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_desc(input int o, input int t, input int s);
    int n;
    r_dp_offset_i = 3'(o);
    r_dp_tailer_i = 3'(t);
    r_dp_shift_i  = 3'(s);
    r_dp_valid_i  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!r_dp_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!r_dp_ready_o) timeout("desc_push");
    tick();
    r_dp_valid_i = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] addr);
    int n;
    ar_addr_i  = addr;
    ar_prot_i  = 3'($urandom);
    ar_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ar_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ar_ready_o) timeout("ar");
    tick();
    ar_valid_i = 1'b0;
  endtask

  task automatic do_r(input logic [63:0] data, input logic [1:0] resp,
                      output logic [7:0] seen, output logic [7:0] seen_nd);
    int n;
    m_r_data_i  = data;
    m_r_resp_i  = resp;
    m_r_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_r_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!m_r_ready_o) timeout("r_beat");
    seen    = buffer_in_valid_o;
    seen_nd = nd_buffer_in_valid_o;
    tick();
    m_r_valid_i = 1'b0;
  endtask

  function automatic logic [1:0] rand_resp();
    int r;
    r = int'($urandom_range(0, 5));
    return (r == 4) ? 2'b10 : (r == 5) ? 2'b11 : 2'b00;
  endfunction

  initial begin : stimulus
    logic [7:0] seen, seen_nd;
    int acc, k;
    rst_i = 1'b1;
    r_dp_offset_i = '0; r_dp_tailer_i = '0; r_dp_shift_i = '0;
    r_dp_valid_i = 1'b0; r_dp_ready_i = 1'b1;
    ar_addr_i = '0; ar_prot_i = '0; ar_valid_i = 1'b0; m_ar_ready_i = 1'b1;
    m_r_data_i = '0; m_r_resp_i = '0; m_r_valid_i = 1'b0;
    buffer_in_ready_i = 8'hFF;
    repeat (3) tick();
    rst_i = 1'b0;

    @(negedge clk);
    chk("rst_state", {r_dp_valid_o, busy_o, outstanding_o, buffer_in_valid_o, m_r_ready_o, r_dp_ready_o, ar_ready_o},
        {1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1});
    tick();
    m_ar_ready_i = 1'b0;
    @(negedge clk);
    chk("rst_ar_ready_follow", 64'(ar_ready_o), 64'h0);
    tick();
    m_ar_ready_i = 1'b1;

    // Mask, no rotation.
    push_desc(2, 6, 0);
    do_ar(32'h1000);
    do_r(64'h0807060504030201, 2'b00, seen, seen_nd);
    chk("mask_3c", 64'(seen), 64'h3C);
    @(negedge clk);
    chk("mask_resp_next", {r_dp_valid_o, r_dp_resp_o}, {1'b1, 2'b00});
    tick();

    // Rotation, with lane 7 initially blocked.
    push_desc(2, 6, 3);
    do_ar(32'h1008);
    buffer_in_ready_i = 8'h7F;
    m_r_data_i = 64'hA5A5_5A5A_0F0F_F0F0;
    m_r_resp_i = 2'b00;
    m_r_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rot_lane7_block", 64'(m_r_ready_o), 64'h0);
      tick();
    end
    buffer_in_ready_i = 8'hFF;
    do_r(64'hA5A5_5A5A_0F0F_F0F0, 2'b00, seen, seen_nd);
    chk("rot_87", 64'(seen), 64'h87);

    // Outstanding limit.
    ar_valid_i = 1'b1;
    ar_addr_i  = 32'h2000;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      if (ar_ready_o) acc++;
      tick();
    end
    chk("ol_accepted", 64'(acc), 64'd4);
    @(negedge clk);
    chk("ol_full", {outstanding_o, ar_ready_o, m_ar_valid_o}, {3'd4, 1'b0, 1'b0});
    tick();
    push_desc(0, 0, 0);
    do_r(64'h1111_2222_3333_4444, 2'b00, seen, seen_nd);
    @(negedge clk);
    chk("ol_reopen", 64'(ar_ready_o), 64'h1);
    tick();
    ar_valid_i = 1'b0;
    repeat (4) begin
      push_desc(1, 0, 1);
      do_r(64'($urandom) << 32 | 64'($urandom), 2'b00, seen, seen_nd);
    end

    // Error beat: dropped by the default instance, written by the other.
    push_desc(0, 0, 0);
    do_ar(32'h3000);
    do_r(64'hDEAD_BEEF_CAFE_F00D, 2'b10, seen, seen_nd);
    chk("err_drop", 64'(seen), 64'h00);
    chk("err_nodrop", 64'(seen_nd), 64'hFF);
    @(negedge clk);
    chk("err_resp", {r_dp_valid_o, r_dp_resp_o}, {1'b1, 2'b10});
    tick();

    // Response-slot backpressure and same-cycle reload.
    r_dp_ready_i = 1'b0;
    push_desc(0, 4, 0);
    push_desc(4, 0, 4);
    do_ar(32'h4000);
    do_ar(32'h4008);
    do_r(64'h0123_4567_89AB_CDEF, 2'b00, seen, seen_nd);
    m_r_data_i = 64'hFEDC_BA98_7654_3210;
    m_r_resp_i = 2'b11;
    m_r_valid_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("bp_stall", 64'(m_r_ready_o), 64'h0);
      tick();
    end
    r_dp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'(m_r_ready_o), 64'h1);
    tick();
    m_r_valid_i = 1'b0;
    @(negedge clk);
    chk("bp_reload", {r_dp_valid_o, r_dp_resp_o}, {1'b1, 2'b11});
    tick();

    // Reset in the middle of work.
    push_desc(1, 5, 2);
    push_desc(3, 0, 1);
    push_desc(0, 7, 6);
    do_ar(32'h5000);
    do_ar(32'h5008);
    do_ar(32'h5010);
    @(negedge clk);
    chk("pre_reset", {outstanding_o, busy_o}, {3'd3, 1'b1});
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("mid_reset", {busy_o, outstanding_o, r_dp_valid_o, r_dp_ready_o}, {1'b0, 3'd0, 1'b0, 1'b1});
    tick();

    // Randomized bursts under random backpressure.
    rnd_en = 1'b1;
    for (int b = 0; b < 40; b++) begin
      k = int'($urandom_range(1, NO));
      for (int i = 0; i < k; i++)
        push_desc(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      for (int i = 0; i < k; i++) do_ar(32'($urandom));
      for (int i = 0; i < k; i++)
        do_r({32'($urandom), 32'($urandom)}, rand_resp(), seen, seen_nd);
    end
    rnd_en = 1'b0;
    tick();
    r_dp_ready_i = 1'b1;
    buffer_in_ready_i = 8'hFF;
    repeat (3) tick();
    @(negedge clk);
    chk("final_idle", {busy_o, nd_busy_o, outstanding_o}, {1'b0, 1'b0, 3'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
